// File: rtl/icache_assoc.sv
// icache_assoc: read-only, word-aligned instruction cache with 1 or 2 ways
// per set, LRU replacement, flush and hit/miss statistics. Misses refill a
// whole line from a BurstRAM controller. The requested instruction is
// forwarded as soon as the beat that carries it arrives.
//
// Ports
//   clk_ram           in   clock, rising edge
//   rst               in   synchronous active-high reset
//   enable            in   fetch request, sampled in IDLE only
//   address           in   byte address (bits [1:0] ignored)
//   flush             in   invalidate every line
//   instruction       out  fetched instruction, holds until next update
//   data_ready        out  one-cycle strobe qualifying instruction
//   busy              out  high while a miss is outstanding
//   stat_hits         out  64-bit wrapping hit counter
//   stat_misses       out  64-bit wrapping miss counter
//   br_cmd            out  BurstRAM command, always read (0)
//   br_cmd_en         out  BurstRAM command strobe
//   br_addr           out  BurstRAM word address of the burst
//   br_wr_data        out  unused write data, tied to 0
//   br_data_mask      out  unused write mask, tied to 0
//   br_rd_data        in   burst read beat
//   br_rd_data_valid  in   qualifies br_rd_data
//   br_busy           in   BurstRAM cannot accept a command
module icache_assoc #(
  parameter int ADDRESS_BITWIDTH                = 32,
  parameter int INSTRUCTION_BITWIDTH            = 32,
  parameter int LINE_IX_BITWIDTH                = 1,
  parameter int INSTRUCTION_IX_IN_LINE_BITWIDTH = 3,
  parameter int WAYS                            = 2,
  parameter int RAM_BURST_DATA_COUNT            = 4,
  parameter int RAM_BURST_DATA_BITWIDTH         = 64,
  parameter int RAM_DEPTH_BITWIDTH              = 8
) (
  input  logic                                   clk_ram,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [ADDRESS_BITWIDTH-1:0]            address,
  input  logic                                   flush,
  output logic [INSTRUCTION_BITWIDTH-1:0]        instruction,
  output logic                                   data_ready,
  output logic                                   busy,
  output logic [63:0]                            stat_hits,
  output logic [63:0]                            stat_misses,
  output logic                                   br_cmd,
  output logic                                   br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
  input  logic                                   br_rd_data_valid,
  input  logic                                   br_busy
);

  localparam int SETS       = 1 << LINE_IX_BITWIDTH;
  localparam int IX_W       = INSTRUCTION_IX_IN_LINE_BITWIDTH;
  localparam int OFF_W      = IX_W + 2;
  localparam int TAG_W      = ADDRESS_BITWIDTH - OFF_W - LINE_IX_BITWIDTH;
  localparam int LINE_W     = (1 << IX_W) * INSTRUCTION_BITWIDTH;
  localparam int IPB        = RAM_BURST_DATA_BITWIDTH / INSTRUCTION_BITWIDTH;
  localparam int IPB_SHIFT  = $clog2(IPB);
  localparam int BEAT_W     = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam int BEAT_SHIFT = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);
  localparam logic [RAM_DEPTH_BITWIDTH-1:0] BEAT_MASK =
    RAM_DEPTH_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FILL} state_t;

  // Control state
  state_t                            r_state;
  logic                              r_busy;
  logic                              r_data_ready;
  logic [INSTRUCTION_BITWIDTH-1:0]   r_instruction;
  logic [RAM_DEPTH_BITWIDTH-1:0]     r_br_addr;
  logic [63:0]                       r_hits;
  logic [63:0]                       r_misses;
  logic                              r_flush_pend;
  logic [BEAT_W-1:0]                 r_beat;
  logic                              r_way;
  logic [SETS-1:0]                   r_valid [WAYS];
  logic [SETS-1:0]                   r_lru;     // per set: way to evict next

  // Storage (no reset: contents are qualified by r_valid)
  logic [ADDRESS_BITWIDTH-1:0]       r_addr;
  logic [TAG_W-1:0]                  r_tag  [WAYS][SETS];
  logic [LINE_W-1:0]                 r_line [WAYS][SETS];

  // Field decode of the incoming address and of the latched request
  logic [TAG_W-1:0]                  w_tag;
  logic [LINE_IX_BITWIDTH-1:0]       w_set;
  logic [IX_W-1:0]                   w_idx;
  logic [LINE_IX_BITWIDTH-1:0]       w_r_set;
  logic [IX_W-1:0]                   w_r_idx;
  logic [ADDRESS_BITWIDTH-1:0]       w_shifted;
  logic [RAM_DEPTH_BITWIDTH-1:0]     w_br_addr;

  assign w_tag     = address[ADDRESS_BITWIDTH-1 -: TAG_W];
  assign w_set     = address[OFF_W +: LINE_IX_BITWIDTH];
  assign w_idx     = address[2 +: IX_W];
  assign w_r_set   = r_addr[OFF_W +: LINE_IX_BITWIDTH];
  assign w_r_idx   = r_addr[2 +: IX_W];
  assign w_shifted = address >> BEAT_SHIFT;
  // Burst always starts at the first beat of the line
  assign w_br_addr = w_shifted[RAM_DEPTH_BITWIDTH-1:0] & ~BEAT_MASK;

  // Tag lookup across all ways of the addressed set
  logic                              w_hit;
  logic                              w_hit_way;
  logic [LINE_W-1:0]                 w_hit_line;
  logic [INSTRUCTION_BITWIDTH-1:0]   w_hit_inst;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_set] && (r_tag[w][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  assign w_hit_line = r_line[w_hit_way][w_set];
  assign w_hit_inst = w_hit_line[w_idx*INSTRUCTION_BITWIDTH +: INSTRUCTION_BITWIDTH];

  // A flush in the same cycle as a request invalidates first, so it can never hit
  logic w_lookup_hit;
  assign w_lookup_hit = w_hit & ~flush;

  // Victim: first invalid way, otherwise the LRU way; after a flush everything is invalid
  logic w_victim;
  generate
    if (WAYS == 1) begin : g_direct
      assign w_victim = 1'b0;
    end else begin : g_two_way
      always_comb begin
        if (flush)                  w_victim = 1'b0;
        else if (!r_valid[0][w_set]) w_victim = 1'b0;
        else if (!r_valid[1][w_set]) w_victim = 1'b1;
        else                         w_victim = r_lru[w_set];
      end
    end
  endgenerate

  // Beat carrying the requested instruction, and that instruction's slice
  logic [BEAT_W-1:0]                 w_req_beat;
  logic [INSTRUCTION_BITWIDTH-1:0]   w_req_inst;

  assign w_req_beat = BEAT_W'(w_r_idx >> IPB_SHIFT);

  always_comb begin
    w_req_inst = br_rd_data[(int'(w_r_idx) % IPB) * INSTRUCTION_BITWIDTH +: INSTRUCTION_BITWIDTH];
  end

  logic w_miss_take;
  logic w_beat_take;
  assign w_miss_take = (r_state == S_IDLE) && enable && !w_lookup_hit;
  assign w_beat_take = (r_state == S_FILL) && br_rd_data_valid;

  // ---- Control FSM ----
  always_ff @(posedge clk_ram) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_data_ready  <= 1'b0;
      r_instruction <= '0;
      r_br_addr     <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_flush_pend  <= 1'b0;
      r_beat        <= '0;
      r_way         <= 1'b0;
      r_lru         <= '0;
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else begin
      r_data_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_lru <= '0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
          end
          if (enable) begin
            if (w_lookup_hit) begin
              r_instruction <= w_hit_inst;
              r_data_ready  <= 1'b1;
              r_hits        <= r_hits + 64'd1;
              r_lru[w_set]  <= ~w_hit_way;
            end else begin
              // Victim is invalid until its last beat lands, so an abort leaves no stale line
              r_misses                 <= r_misses + 64'd1;
              r_valid[w_victim][w_set] <= 1'b0;
              r_way                    <= w_victim;
              r_br_addr                <= w_br_addr;
              r_beat                   <= '0;
              r_busy                   <= 1'b1;
              r_state                  <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (flush) r_flush_pend <= 1'b1;
          if (!br_busy) r_state <= S_FILL;
        end

        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (br_rd_data_valid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == w_req_beat) begin
              r_instruction <= w_req_inst;
              r_data_ready  <= 1'b1;
            end
            if (r_beat == LAST_BEAT) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_flush_pend <= 1'b0;
              // A flush seen during the miss also discards the line just filled
              if (flush || r_flush_pend) begin
                r_lru <= '0;
                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
              end else begin
                r_valid[r_way][w_r_set] <= 1'b1;
                r_lru[w_r_set]          <= ~r_way;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- Tag / line storage ----
  always_ff @(posedge clk_ram) begin
    if (w_miss_take) begin
      r_addr                 <= address;
      r_tag[w_victim][w_set] <= w_tag;
    end
    if (w_beat_take) begin
      r_line[r_way][w_r_set][r_beat*RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH] <= br_rd_data;
    end
  end

  // Command strobe is combinational on br_busy so it fires in the very
  // ISSUE cycle the controller becomes free; the FSM leaves ISSUE on that edge.
  assign br_cmd_en    = (r_state == S_ISSUE) && !br_busy;
  assign br_cmd       = 1'b0;
  assign br_addr      = r_br_addr;
  assign br_wr_data   = '0;
  assign br_data_mask = '0;

  assign instruction  = r_instruction;
  assign data_ready   = r_data_ready;
  assign busy         = r_busy;
  assign stat_hits    = r_hits;
  assign stat_misses  = r_misses;

  // Byte-offset bits, upper shifted bits, latched tag and (for one way) LRU are not consumed
  logic w_unused;
  assign w_unused = ^{address[1:0], w_shifted, r_addr, r_lru};

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;

  logic         clk_ram = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [31:0]  address = '0;
  logic         flush = 1'b0;
  logic [31:0]  instruction;
  logic         data_ready;
  logic         busy;
  logic [63:0]  stat_hits;
  logic [63:0]  stat_misses;
  logic         br_cmd;
  logic         br_cmd_en;
  logic [7:0]   br_addr;
  logic [63:0]  br_wr_data;
  logic [7:0]   br_data_mask;
  logic [63:0]  br_rd_data = '0;
  logic         br_rd_data_valid = 1'b0;
  logic         br_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_cmd = 0;
  int n_dr  = 0;
  logic [7:0] ram_a;

  always #5 clk_ram = ~clk_ram;

  icache_assoc #(
    .ADDRESS_BITWIDTH(32), .INSTRUCTION_BITWIDTH(32), .LINE_IX_BITWIDTH(1),
    .INSTRUCTION_IX_IN_LINE_BITWIDTH(3), .WAYS(2), .RAM_BURST_DATA_COUNT(4),
    .RAM_BURST_DATA_BITWIDTH(64), .RAM_DEPTH_BITWIDTH(8)
  ) dut (
    .clk_ram(clk_ram), .rst(rst), .enable(enable), .address(address), .flush(flush),
    .instruction(instruction), .data_ready(data_ready), .busy(busy),
    .stat_hits(stat_hits), .stat_misses(stat_misses),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  // Pulse counters: each cycle's value is counted once, at the edge that ends it
  always @(posedge clk_ram) begin
    if (br_cmd_en)  n_cmd <= n_cmd + 1;
    if (data_ready) n_dr  <= n_dr + 1;
  end

  // RAM word k = {0xA0000000 + 2k + 1, 0xA0000000 + 2k}
  function automatic logic [63:0] ram_word(input logic [7:0] k);
    logic [31:0] base;
    base = 32'hA000_0000 + 32'(k) * 32'd2;
    return {base + 32'd1, base};
  endfunction

  // BurstRAM model: command seen mid-cycle, four consecutive beats from the next negedge on
  always begin
    @(negedge clk_ram);
    if (br_cmd_en) begin
      ram_a = br_addr;
      @(negedge clk_ram);
      for (int b = 0; b < 4; b++) begin
        br_rd_data       = ram_word(ram_a + 8'(b));
        br_rd_data_valid = 1'b1;
        @(negedge clk_ram);
      end
      br_rd_data_valid = 1'b0;
      br_rd_data       = '0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic fl);
    enable  = 1'b1;
    address = a;
    flush   = fl;
    tick();
    enable  = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wait_cmd(input logic [7:0] exp_ba);
    int k;
    k = 0;
    while (!br_cmd_en && k < 30) begin tick(); k++; end
    check_val("cmd_en", 64'(br_cmd_en), 64'd1);
    check_val("br_addr", 64'(br_addr), 64'(exp_ba));
    check_val("br_cmd", 64'(br_cmd), 64'd0);
  endtask

  task automatic wait_fill(input logic [31:0] exp);
    int k;
    k = 0;
    tick();
    while (!data_ready && k < 30) begin tick(); k++; end
    check_val("fill data_ready", 64'(data_ready), 64'd1);
    check_val("fill instruction", 64'(instruction), 64'(exp));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 30) begin tick(); k++; end
    check_val("busy fall", 64'(busy), 64'd0);
  endtask

  task automatic miss(input logic [31:0] a, input logic fl, input logic [7:0] ba, input logic [31:0] exp);
    logic [63:0] m0;
    int c0;
    int d0;
    m0 = stat_misses;
    c0 = n_cmd;
    d0 = n_dr;
    req(a, fl);
    check_val("miss busy", 64'(busy), 64'd1);
    check_val("miss no early data", 64'(data_ready), 64'd0);
    wait_cmd(ba);
    wait_fill(exp);
    wait_idle();
    tick();
    check_val("stat_misses", stat_misses, m0 + 64'd1);
    check_val("cmd pulses", 64'(n_cmd), 64'(c0 + 1));
    check_val("data_ready pulses", 64'(n_dr), 64'(d0 + 1));
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] exp);
    logic [63:0] h0;
    int c0;
    h0 = stat_hits;
    c0 = n_cmd;
    req(a, 1'b0);
    check_val("hit data_ready", 64'(data_ready), 64'd1);
    check_val("hit instruction", 64'(instruction), 64'(exp));
    check_val("hit busy", 64'(busy), 64'd0);
    check_val("stat_hits", stat_hits, h0 + 64'd1);
    tick();
    check_val("hit single pulse", 64'(data_ready), 64'd0);
    check_val("hit instruction hold", 64'(instruction), 64'(exp));
    check_val("hit no command", 64'(n_cmd), 64'(c0));
  endtask

  initial begin
    repeat (3) tick();
    check_val("rst instruction", 64'(instruction), 64'd0);
    check_val("rst data_ready", 64'(data_ready), 64'd0);
    check_val("rst busy", 64'(busy), 64'd0);
    check_val("rst br_cmd_en", 64'(br_cmd_en), 64'd0);
    check_val("rst br_addr", 64'(br_addr), 64'd0);
    check_val("rst br_wr_data", br_wr_data, 64'd0);
    check_val("rst br_data_mask", 64'(br_data_mask), 64'd0);
    check_val("rst stat_hits", stat_hits, 64'd0);
    check_val("rst stat_misses", stat_misses, 64'd0);
    rst = 1'b0;
    tick();

    // Cold miss, then hit in the same line
    miss(32'h08, 1'b0, 8'h00, 32'hA000_0002);
    hit(32'h1C, 32'hA000_0007);

    // Flush in IDLE, then the same address misses again
    flush = 1'b1;
    tick();
    flush = 1'b0;
    miss(32'h1C, 1'b0, 8'h00, 32'hA000_0007);

    // Flush together with a request: evaluated after invalidation
    miss(32'h00, 1'b1, 8'h00, 32'hA000_0000);
    // LRU replacement in set 0
    miss(32'h40, 1'b0, 8'h08, 32'hA000_0010);
    hit(32'h00, 32'hA000_0000);
    miss(32'h80, 1'b0, 8'h10, 32'hA000_0020);
    hit(32'h00, 32'hA000_0000);
    miss(32'h40, 1'b0, 8'h08, 32'hA000_0010);

    // Flush during a miss discards the line being filled
    req(32'h20, 1'b0);
    wait_cmd(8'h04);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_fill(32'hA000_0008);
    wait_idle();
    tick();
    miss(32'h20, 1'b0, 8'h04, 32'hA000_0008);

    // br_busy held for three ISSUE cycles
    br_busy = 1'b1;
    req(32'hC4, 1'b0);
    check_val("stall busy", 64'(busy), 64'd1);
    check_val("stall cycle 1", 64'(br_cmd_en), 64'd0);
    tick();
    check_val("stall cycle 2", 64'(br_cmd_en), 64'd0);
    tick();
    check_val("stall cycle 3", 64'(br_cmd_en), 64'd0);
    br_busy = 1'b0;
    #1;
    check_val("cmd after br_busy falls", 64'(br_cmd_en), 64'd1);
    check_val("stall br_addr", 64'(br_addr), 64'h18);
    wait_fill(32'hA000_0031);
    wait_idle();
    tick();

    // Reset in the middle of a fill
    req(32'h68, 1'b0);
    check_val("pre-rst busy", 64'(busy), 64'd1);
    wait_cmd(8'h0C);
    wait_fill(32'hA000_001A);
    rst = 1'b1;
    tick();
    check_val("mid-fill rst busy", 64'(busy), 64'd0);
    check_val("mid-fill rst data_ready", 64'(data_ready), 64'd0);
    check_val("mid-fill rst instruction", 64'(instruction), 64'd0);
    check_val("mid-fill rst stat_misses", stat_misses, 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    check_val("late beats ignored", 64'(data_ready), 64'd0);
    miss(32'h68, 1'b0, 8'h0C, 32'hA000_001A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised, read-only instruction cache that serves word-aligned fetches from an N-set, 1- or 2-way array. Misses are refilled from a BurstRAM controller through the br_* port, and the requested instruction is forwarded as soon as its burst beat arrives. Compared with the previous direct-mapped cache it adds:
- set associativity with LRU replacement;
- a flush input that invalidates all lines;
- stall on br_busy before a command is issued;
- a latched request address;
- exported hit/miss counters.

## Interface
- ADDRESS_BITWIDTH, 32, byte address width.
- INSTRUCTION_BITWIDTH, 32, instruction width; multiple of 8.
- LINE_IX_BITWIDTH, 1, log2 of the set count.
- INSTRUCTION_IX_IN_LINE_BITWIDTH, 3, log2 of instructions per line.
- WAYS, 2, associativity; legal values are 1 and 2.
- RAM_BURST_DATA_COUNT, 4, beats per burst.
- RAM_BURST_DATA_BITWIDTH, 64, beat width; must be a multiple of INSTRUCTION_BITWIDTH.
- RAM_DEPTH_BITWIDTH, 8, BurstRAM word-address width.
- Constraint: RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH == 2^INSTRUCTION_IX_IN_LINE_BITWIDTH * INSTRUCTION_BITWIDTH.

Ports (reset rst, synchronous, active-high; clock clk_ram):
- clk_ram  in  1  all logic clocked on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  fetch request; sampled only in IDLE
- address  in  ADDRESS_BITWIDTH  byte address; bits [1:0] are ignored
- flush  in  1  invalidate all lines
- instruction  out  INSTRUCTION_BITWIDTH  fetched instruction
- data_ready  out  1  one-cycle pulse marking instruction as valid
- busy  out  1  high while a miss is outstanding
- stat_hits, stat_misses  out  64 each  saturating-free wrap counters
- br_cmd  out  1  BurstRAM command; always 0 (read)
- br_cmd_en  out  1  command strobe
- br_addr  out  RAM_DEPTH_BITWIDTH  BurstRAM word address
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  tied to 0
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  tied to 0
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  burst read data
- br_rd_data_valid  in  1  marks a valid br_rd_data beat
- br_busy  in  1  BurstRAM cannot accept a command

## Operation
- Address fields, from high to low: tag | set | instruction index | 2'b00.
- Within a beat, the lower bit-slice holds the lower address.
- States:
  - IDLE.
  - ISSUE: wait for br_busy low, then strobe the command.
  - FILL: collect beats.
- IDLE, with enable:
  - Latch address, then compare the tag against both ways of the set.
  - Hit: output the instruction and increment stat_hits. When WAYS=2, set the set's LRU bit to the way that was not hit.
  - Miss: increment stat_misses and select the victim. The victim is the first invalid way (way 0 first), otherwise the LRU way. Clear the victim's valid bit, write its tag, and go to ISSUE.
- ISSUE:
  - If br_busy=0, pulse br_cmd_en for exactly one cycle and go to FILL.
  - br_addr = (latched address >> log2(RAM_BURST_DATA_BITWIDTH/8)), with the low log2(RAM_BURST_DATA_COUNT) bits cleared, truncated to RAM_DEPTH_BITWIDTH.
- FILL:
  - Each cycle with br_rd_data_valid=1 writes one beat into the victim line and advances the beat counter.
  - The beat containing the requested index also drives instruction and data_ready.
  - On the last beat: set the victim valid, set LRU to the other way, clear busy, and return to IDLE.
- Flush:
  - In IDLE, clears all valid bits and LRU bits at that edge. A simultaneous enable is evaluated against the flushed state, so it is a miss.
  - Outside IDLE, flush is remembered and applied on the edge that returns to IDLE; the line just filled is also invalidated.
- Ignored inputs: enable outside IDLE, and br_rd_data_valid in IDLE/ISSUE.

## Timing
- Reset values: instruction=0, data_ready=0, busy=0, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0, br_data_mask=0, stat_*=0. All valid and LRU bits are 0, state is IDLE, and any pending flush is cleared.
- Hit: enable sampled at edge N; instruction and data_ready=1 at N+1; busy stays 0.
- Miss:
  - busy=1 from N+1.
  - br_cmd_en=1 in the first ISSUE cycle with br_busy=0, at the earliest N+1.
  - data_ready pulses in the cycle after the matching beat edge.
  - busy=0 in the cycle after the last-beat edge.
  - Minimum miss-to-IDLE latency: 2 + first-beat latency + RAM_BURST_DATA_COUNT cycles.
- data_ready is high for exactly one cycle per request. instruction holds its value until the next update.
- rst mid-fill: all lines become invalid and the partial line is discarded. Later beats are ignored; the next request to the same address misses.

## Test plan
- Cold miss: RAM word k = {0xA0000000+2k+1, 0xA0000000+2k}; enable at 0x08 -> br_cmd_en pulse with br_addr=0x00; instruction=0xA0000002 after beat 1; busy falls after beat 3; stat_misses=1.
- Hit: 0x1C after the cold miss -> 0xA0000007 one cycle later, no br_cmd_en, stat_hits=1.
- LRU: fill 0x00 then 0x40 (br_addr=0x08), hit 0x00, miss 0x80 (br_addr=0x10) -> the 0x40 line is evicted; 0x00 hits; 0x40 misses.
- Flush: flush pulse after the hit test, then 0x1C -> miss with br_addr=0x00 and stat_misses incremented.
- br_busy held high for 3 cycles on a miss -> br_cmd_en is asserted in the first cycle after br_busy falls, and not before.
- rst asserted after beat 1 of a fill -> busy=0 and data_ready=0 next cycle; a re-request of the same address misses.
